demux1t4_32_slot: RTL and testbench

// - 32-bit 1-to-4 write distributor: routes one input word, tagged with a 2-bit channel select, to one of four outputs.
// - Each output channel holds its word in a one-entry register under a valid/ready handshake.
// - It is the write-side counterpart of the 4-to-1 read selector in the multi-cycle datapath.
// - It feeds the register-file, memory-write, peripheral and debug sinks.

---
 rtl/dmux_pkg.sv | 18 +
 rtl/dmux_slot.sv | 46 ++++
 rtl/demux1t4_32_slot.sv | 76 +++++++
 tb/tb_demux1t4_32_slot.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared constants and types for the 1-to-4 write distributor.
// Counter feature is enabled by the DMUX_CNT_EN macro in the top module.
package dmux_pkg;

  localparam int unsigned CH_NUM    = 4;
  localparam int unsigned DEF_WIDTH = 32;

  typedef logic [1:0] ch_sel_t;

  // One-hot channel mask for a channel select value.
  function automatic logic [CH_NUM-1:0] sel_onehot(input ch_sel_t sel);
    logic [CH_NUM-1:0] mask;
    mask = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/dmux_slot.sv
// One-entry holding register for a single output channel.
// A load always wins over a drain, so a same-cycle drain+load keeps valid high.
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Next-state: load replaces the word; a drain only clears valid, data is kept.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/demux1t4_32_slot.sv
// 32-bit 1-to-4 write distributor with per-channel one-entry registers.
// Optional per-channel accept counters: define DMUX_CNT_EN.
module demux1t4_32_slot
  import dmux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
`ifdef DMUX_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  ch_sel_t           s,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [WIDTH-1:0]  I,
  output logic [WIDTH-1:0]  o0,
  output logic [WIDTH-1:0]  o1,
  output logic [WIDTH-1:0]  o2,
  output logic [WIDTH-1:0]  o3,
  output logic [CH_NUM-1:0] o_valid,
  input  logic [CH_NUM-1:0] o_ready
`ifdef DMUX_CNT_EN
  ,
  input  ch_sel_t           cnt_sel,
  output logic [CNT_W-1:0]  cnt_o
`endif
);

  logic              accept;
  logic [CH_NUM-1:0] load_vec;
  logic [WIDTH-1:0]  data_w [CH_NUM];

  // Ready when the target slot is empty or is being drained this cycle.
  always_comb begin
    i_ready  = !o_valid[s] || o_ready[s];
    accept   = i_valid && i_ready;
    load_vec = accept ? sel_onehot(s) : '0;
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_slot
    dmux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_vec[k]),
      .data_i (I),
      .ready_i(o_ready[k]),
      .data_o (data_w[k]),
      .valid_o(o_valid[k])
    );
  end

  assign o0 = data_w[0];
  assign o1 = data_w[1];
  assign o2 = data_w[2];
  assign o3 = data_w[3];

`ifdef DMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [CH_NUM];

  // Per-channel accept counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CH_NUM; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      cnt_q[s] <= cnt_q[s] + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q[cnt_sel];
`endif

endmodule

// File: tb/tb_demux1t4_32_slot.sv
// Directed self-checking bench for demux1t4_32_slot.
// Counter scenario is built only when DMUX_CNT_EN is defined.
module tb_demux1t4_32_slot;
  import dmux_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  ch_sel_t     s;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] I;
  logic [31:0] o0, o1, o2, o3;
  logic [3:0]  o_valid;
  logic [3:0]  o_ready;
`ifdef DMUX_CNT_EN
  ch_sel_t     cnt_sel;
  logic [3:0]  cnt_o;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

`ifdef DMUX_CNT_EN
  demux1t4_32_slot #(.WIDTH(32), .CNT_W(4)) dut (
`else
  demux1t4_32_slot #(.WIDTH(32)) dut (
`endif
    .clk(clk), .rst(rst), .s(s), .i_valid(i_valid), .i_ready(i_ready), .I(I),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o_valid(o_valid), .o_ready(o_ready)
`ifdef DMUX_CNT_EN
    , .cnt_sel(cnt_sel), .cnt_o(cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; s = 2'd0; I = '0; o_ready = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=0000", o_valid); end
    checks++; if ({o0, o1, o2, o3} !== 128'd0) begin errors++; $display("FAIL reset_data got=%h %h %h %h exp=0", o0, o1, o2, o3); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_iready got=%b exp=1", i_ready); end
  endtask

  task automatic test_load_ch2();
    I = 32'hDEADBEEF; s = 2'd2; i_valid = 1'b1; o_ready = '0;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL load_iready got=%b exp=1", i_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_valid !== 4'b0100) begin errors++; $display("FAIL load_valid got=%b exp=0100", o_valid); end
    checks++; if (o2 !== 32'hDEADBEEF) begin errors++; $display("FAIL load_o2 got=%h exp=deadbeef", o2); end
    checks++; if ({o0, o1, o3} !== 96'd0) begin errors++; $display("FAIL load_others got=%h %h %h exp=0", o0, o1, o3); end
  endtask

  task automatic test_backpressure();
    I = 32'h11111111; s = 2'd2; i_valid = 1'b1; o_ready = '0;
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL bp_full_iready got=%b exp=0", i_ready); end
    tick();
    checks++; if (o2 !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold_o2 got=%h exp=deadbeef", o2); end
    I = 32'hCAFEF00D; s = 2'd1;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_ch1_iready got=%b exp=1", i_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (o_valid !== 4'b0110) begin errors++; $display("FAIL bp_valid got=%b exp=0110", o_valid); end
    checks++; if (o1 !== 32'hCAFEF00D) begin errors++; $display("FAIL bp_o1 got=%h exp=cafef00d", o1); end
  endtask

  task automatic test_drain_load();
    I = 32'hA5A5A5A5; s = 2'd0; i_valid = 1'b1; o_ready = '0;
    tick();
    checks++; if (o_valid !== 4'b0111 || o0 !== 32'hA5A5A5A5) begin errors++; $display("FAIL dl_fill got=%b/%h exp=0111/a5a5a5a5", o_valid, o0); end
    I = 32'h12345678; o_ready = 4'b0001;
    #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL dl_iready got=%b exp=1", i_ready); end
    tick();
    i_valid = 1'b0;
    checks++; if (o0 !== 32'h12345678) begin errors++; $display("FAIL dl_o0 got=%h exp=12345678", o0); end
    checks++; if (o_valid !== 4'b0111) begin errors++; $display("FAIL dl_valid got=%b exp=0111", o_valid); end
    tick();
    o_ready = '0;
    checks++; if (o_valid !== 4'b0110) begin errors++; $display("FAIL dl_drain_valid got=%b exp=0110", o_valid); end
    checks++; if (o0 !== 32'h12345678) begin errors++; $display("FAIL dl_drain_keep got=%h exp=12345678", o0); end
  endtask

  task automatic test_stream();
    o_ready = 4'b1000; s = 2'd3;
    for (int k = 0; k < 8; k++) begin
      I = 32'h30000000 + 32'(k); i_valid = 1'b1;
      #1;
      checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL stream_iready k=%0d got=%b exp=1", k, i_ready); end
      if (k > 0) begin
        checks++;
        if (o_valid[3] !== 1'b1 || o3 !== 32'h30000000 + 32'(k - 1)) begin
          errors++; $display("FAIL stream_sink k=%0d got=%b/%h exp=1/%h", k, o_valid[3], o3, 32'h30000000 + 32'(k - 1));
        end
      end
      tick();
    end
    i_valid = 1'b0;
    checks++; if (o_valid[3] !== 1'b1 || o3 !== 32'h30000007) begin errors++; $display("FAIL stream_last got=%b/%h exp=1/30000007", o_valid[3], o3); end
    tick();
    checks++; if (o_valid !== 4'b0110) begin errors++; $display("FAIL stream_empty got=%b exp=0110", o_valid); end
    o_ready = '0;
  endtask

  task automatic test_multi_drain();
    i_valid = 1'b0; o_ready = 4'b0110;
    tick();
    o_ready = '0;
    checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL mdrain_valid got=%b exp=0000", o_valid); end
    checks++; if (o1 !== 32'hCAFEF00D || o2 !== 32'hDEADBEEF) begin errors++; $display("FAIL mdrain_keep got=%h %h exp=cafef00d deadbeef", o1, o2); end
  endtask

  task automatic test_reset_mid();
    i_valid = 1'b1; s = 2'd0; I = 32'h0000AAAA; tick();
    s = 2'd3; I = 32'h0000BBBB; tick();
    checks++; if (o_valid !== 4'b1001) begin errors++; $display("FAIL rmid_fill got=%b exp=1001", o_valid); end
    rst = 1'b1; s = 2'd1; I = 32'h0000CCCC;
    tick();
    rst = 1'b0; i_valid = 1'b0;
    checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL rmid_valid got=%b exp=0000", o_valid); end
    checks++; if ({o0, o1, o2, o3} !== 128'd0) begin errors++; $display("FAIL rmid_data got=%h %h %h %h exp=0", o0, o1, o2, o3); end
    tick();
    checks++; if (o_valid !== 4'b0000) begin errors++; $display("FAIL rmid_after got=%b exp=0000", o_valid); end
  endtask

`ifdef DMUX_CNT_EN
  task automatic test_counters();
    logic [3:0] exp_cnt [4];
    exp_cnt[0] = 4'd0; exp_cnt[1] = 4'd1; exp_cnt[2] = 4'd0; exp_cnt[3] = 4'd0;
    rst = 1'b1; i_valid = 1'b0; tick(); rst = 1'b0;
    o_ready = 4'b0010; s = 2'd1; i_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      I = 32'(k); tick();
    end
    i_valid = 1'b0; o_ready = '0;
    for (int c = 0; c < 4; c++) begin
      cnt_sel = ch_sel_t'(c);
      #1;
      checks++; if (cnt_o !== exp_cnt[c]) begin errors++; $display("FAIL cnt_ch%0d got=%0d exp=%0d", c, cnt_o, exp_cnt[c]); end
    end
  endtask
`endif

  initial begin
`ifdef DMUX_CNT_EN
    cnt_sel = 2'd0;
`endif
    test_reset();
    test_load_ch2();
    test_backpressure();
    test_drain_load();
    test_stream();
    test_multi_drain();
    test_reset_mid();
`ifdef DMUX_CNT_EN
    test_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
